req_queue_mux: RTL
==================

// Module: req_queue_mux
// PURPOSE
//  Front end for the weighted round-robin arbiter.
//  - Buffers N independent source streams in per-source FIFOs.
//  - Drives the arbiter's req vector from FIFO occupancy.
//  - Consumes its one-hot grant to pop the granted FIFO into one registered output with valid/ready.
//  - Sits between the N requesters and the shared downstream sink; the arbiter sits beside it, combinationally.
// PARAMETERS
//  N      `N (defines.vh)  number of sources; must match the arbiter width
//  DW     32               data width per source
//  DEPTH  4                entries per source FIFO; power of 2, >= 2
//  SW     $clog2(N)        width of out_src
// PORTS
//  clk        in   1     single clock, rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  in_valid   in   N     per-source valid
//  in_ready   out  N     per-source ready: FIFO i not full
//  in_data    in   N*DW  source i data at [i*DW +: DW]
//  arb_req    out  N     request vector to the arbiter
//  arb_grant  in   N     grant vector from the arbiter (expected one-hot or zero)
//  out_valid  out  1     output register holds a beat
//  out_ready  in   1     downstream accepts the beat
//  out_data   out  DW    payload of the held beat
//  out_src    out  SW    source index of the held beat
//  grant_err  out  1     sticky grant error; present only with REQ_QUEUE_MUX_GCHK_EN
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all FIFO counts and pointers = 0; out_valid = 0; out_data = 0; out_src = 0; grant_err = 0.
//   - Hence in_ready = all 1s and arb_req = 0.
//   - Reset mid-operation discards all queued and held beats.
//  Push: FIFO i writes when in_valid[i] & in_ready[i].
//   - in_ready[i] = (count_i != DEPTH), decoded from registered count only.
//   - A pop in the same cycle does not raise in_ready: no grant->in_ready combinational path.
//  slot_free = ~out_valid | out_ready.
//  arb_req[i] = (count_i != 0) & slot_free. The arbiter therefore never sees a request it cannot serve.
//   Every cycle with |arb_grant is a real transfer, so arbiter weight counters stay exact.
//  gsel = arb_grant & arb_req. Grant bits to non-requesting sources are ignored.
//  Pop, when |gsel:
//   - The selected source is the lowest set index of gsel.
//   - Its FIFO head goes to out_data and its index to out_src; out_valid <= 1.
//   - Its read pointer and count advance.
//  No gsel and out_ready: out_valid <= 0. out_data and out_src hold their last value.
//  Stall (out_valid & ~out_ready): arb_req = 0; out_* hold stable.
//  Latency and throughput:
//   - Push at edge t -> arb_req at t+1 -> out_valid at t+2 (minimum).
//   - Sustained 1 beat/cycle while out_ready = 1.
//  Simultaneous push and pop on the same FIFO: count unchanged; pointers both advance.
//   - Full FIFO: pop only, since in_ready = 0.
//   - Empty FIFO: cannot be popped, since arb_req = 0.
//  Pointer wrap-around: AW = $clog2(DEPTH) bits, natural modulo wrap; count is AW+1 bits.
//  Per-source ordering is FIFO. No cross-source ordering is guaranteed.
// CONFIGURATION
//  REQ_QUEUE_MUX_GCHK_EN defined:
//   - grant_err port exists.
//   - Set on any cycle where arb_grant is multi-hot, or arb_grant & ~arb_req != 0.
//   - Stays set until reset. Datapath behaviour is identical either way.
//  Undefined: no grant_err port and no check logic. Selection is still lowest-index of gsel.
// STRUCTURE
//  Shared package req_mux_pkg:
//   - DW and DEPTH defaults.
//   - function clog2.
//   - function lsb_onehot2idx(N-bit) -> SW index.
//  Sub-module sync_fifo_reg (DW, DEPTH): register-array FIFO exposing push, pop, head, count, full, empty.
//   - Instantiated N times via generate.
//   - The pop mux, output register and req/grant glue live in req_queue_mux.
// TESTING
//  1. Reset, N=4, no stimulus -> in_ready=4'b1111, arb_req=0, out_valid=0 for 10 cycles.
//  2. Src1 pushes 0xA1 at edge t, out_ready=1, arbiter grants 4'b0010
//     -> arb_req=4'b0010 at t+1; out_valid=1, out_data=0xA1, out_src=1 at t+2.
//  3. Src0 pushes DEPTH=4 beats with out_ready=0 -> in_ready[0]=0 after 4th push.
//     5th beat held off; later pops return beats in push order.
//  4. One beat in output register, out_ready=0 for 5 cycles
//     -> arb_req=0, out_data/out_src stable; beat released on first out_ready=1 cycle.
//  5. Full src2 FIFO, simultaneous push attempt and grant -> one pop, no push.
//     Count goes 4->3; in_ready[2] rises only the next cycle.
//  6. With REQ_QUEUE_MUX_GCHK_EN, force arb_grant=4'b0110 with both queues non-empty
//     -> src1 popped, grant_err=1 and sticky until reset_n=0.

Source files
------------

// File: rtl/req_mux_pkg.sv
// -----------------------------------------------------------------------------
// req_mux_pkg
//   Shared definitions for the request queue multiplexer front end.
//   - Default data width and per-source FIFO depth.
//   - clog2: elaboration-time ceiling log2 used for pointer and index widths.
//   - lsb_onehot2idx: index of the lowest set bit of a request/grant vector.
//     The vector is zero-extended to IDX_VEC_W bits, so callers with N <= 32
//     sources pass their vector and take the low SW bits of the result.
// -----------------------------------------------------------------------------
package req_mux_pkg;

    localparam int DW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 4;

    // Widest source vector the index helper understands, and its index width.
    localparam int IDX_VEC_W = 32;
    localparam int IDX_W     = 5;

    // Smallest r such that 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index of the lowest set bit. An all-zero vector yields index 0; callers
    // qualify the result with the OR of the vector.
    function automatic logic [IDX_W-1:0] lsb_onehot2idx(input logic [IDX_VEC_W-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        // Scan downward so the last hit, i.e. the lowest index, wins.
        for (int i = IDX_VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_fifo_reg.sv
// -----------------------------------------------------------------------------
// sync_fifo_reg
//   Single-clock register-array FIFO holding one source's pending beats.
//   Pointers wrap naturally over AW = clog2(DEPTH) bits; the occupancy count
//   is AW+1 bits so that "full" (count == DEPTH) is distinguishable from empty.
//   Storage is not reset: only the count and pointers define which entries
//   are live, so stale contents are never observable.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset (count/pointers)
//   push       in   1       write push_data at the tail (ignored when full)
//   push_data  in   DW      beat to enqueue
//   pop        in   1       drop the head entry (ignored when empty)
//   head       out  DW      entry at the read pointer
//   count      out  AW+1    number of live entries, 0..DEPTH
//   full       out  1       count == DEPTH
//   empty      out  1       count == 0
// -----------------------------------------------------------------------------
module sync_fifo_reg
    import req_mux_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Self-protecting: an overflowing push or underflowing pop is dropped
    // rather than corrupting the pointers.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/req_queue_mux.sv
// -----------------------------------------------------------------------------
// req_queue_mux
//   Front end for the weighted round-robin arbiter. Each of N sources feeds
//   its own sync_fifo_reg; non-empty FIFOs raise arb_req whenever the single
//   output register can take a beat, and the arbiter's grant pops the granted
//   FIFO head into that register (valid/ready towards the shared sink).
//
//   Because arb_req is gated by slot availability, every cycle that carries a
//   grant to a requesting source is a real transfer, keeping the arbiter's
//   weight accounting exact. Grant bits towards non-requesting sources are
//   ignored, and a multi-hot grant resolves to its lowest requesting index.
//
//   in_ready depends only on the registered FIFO count, so there is no
//   combinational path from arb_grant to in_ready: a pop frees a slot for
//   pushing only from the following cycle.
//
// Configuration
//   REQ_QUEUE_MUX_GCHK_EN  when defined, adds the sticky grant_err output,
//                          set by a multi-hot grant or a grant bit towards a
//                          non-requesting source; cleared only by reset.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   N      per-source valid
//   in_ready   out  N      per-source ready (FIFO i not full)
//   in_data    in   N*DW   source i data at [i*DW +: DW]
//   arb_req    out  N      request vector to the arbiter
//   arb_grant  in   N      grant vector from the arbiter (one-hot or zero)
//   out_valid  out  1      output register holds a beat
//   out_ready  in   1      downstream accepts the beat
//   out_data   out  DW     payload of the held beat
//   out_src    out  SW     source index of the held beat
//   grant_err  out  1      sticky grant error (REQ_QUEUE_MUX_GCHK_EN only)
// -----------------------------------------------------------------------------
module req_queue_mux
    import req_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int SW    = (N > 1) ? clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    arb_req,
    input  logic [N-1:0]    arb_grant,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [SW-1:0]   out_src
`ifdef REQ_QUEUE_MUX_GCHK_EN
    ,
    output logic            grant_err
`endif
);

    localparam int CW = clog2(DEPTH) + 1;

    logic [DW-1:0] fifo_head [N];
    logic [CW-1:0] fifo_count_unused [N];
    logic [N-1:0]  fifo_full;
    logic [N-1:0]  fifo_empty;
    logic [N-1:0]  fifo_pop;

    logic           slot_free;
    logic [N-1:0]   gsel;
    logic           gsel_any;
    logic [IDX_W-1:0] sel_idx_full;
    logic [SW-1:0]  sel_idx;

    // Per-source FIFOs; the head of each is presented to the pop mux below.
    for (genvar g = 0; g < N; g++) begin : g_src
        sync_fifo_reg #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (in_valid[g] & in_ready[g]),
            .push_data (in_data[g*DW +: DW]),
            .pop       (fifo_pop[g]),
            .head      (fifo_head[g]),
            .count     (fifo_count_unused[g]),
            .full      (fifo_full[g]),
            .empty     (fifo_empty[g])
        );
    end

    assign in_ready = ~fifo_full;

    // The output register can accept a new beat when it is empty or its
    // current beat leaves this cycle; otherwise nobody is allowed to request.
    assign slot_free = ~out_valid | out_ready;
    assign arb_req   = ~fifo_empty & {N{slot_free}};

    // Only grants that land on a live request count; the lowest of those wins.
    assign gsel     = arb_grant & arb_req;
    assign gsel_any = |gsel;
    assign fifo_pop = gsel & (~gsel + 1'b1);

    assign sel_idx_full = lsb_onehot2idx(IDX_VEC_W'(gsel));
    assign sel_idx      = sel_idx_full[SW-1:0];

    // Output register stage: load on a pop, empty on a drain, else hold.
    // out_data/out_src keep their last value when the register empties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (gsel_any) begin
            out_valid <= 1'b1;
            out_data  <= fifo_head[sel_idx];
            out_src   <= sel_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef REQ_QUEUE_MUX_GCHK_EN
    logic grant_multi_hot;
    logic grant_stray;

    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    assign grant_multi_hot = |(arb_grant & (arb_grant - 1'b1));
    assign grant_stray     = |(arb_grant & ~arb_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_err <= 1'b0;
        end else if (grant_multi_hot | grant_stray) begin
            grant_err <= 1'b1;
        end
    end
`endif

endmodule
